double_adder_arbiter: RTL and testbench

Shares one `double_adder` between two independent requesters. Each requester presents an operand pair (a, b) on a stb/ack port and receives the 64-bit sum on its own result port. The block sits between the requesters and a `double_adder` instance in the enclosing test bench or top level, and sequences exactly one addition at a time. Round-robin arbitration keeps either requester from starving the other.

---
 rtl/double_adder_pkg.sv | 19 +
 rtl/rr_pick2.sv | 23 ++
 rtl/double_adder_arbiter.sv | 171 +++++++++++++++++
 tb/tb_double_adder_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/double_adder_pkg.sv
// Shared definitions for the double_adder arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package double_adder_pkg;

  // Operand/result width: an IEEE-754 double.
  localparam int WIDTH_DEFAULT = 64;

  // Arbiter sequencing states; the encoding is shared with anything that
  // observes the state (monitors, debug taps).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    SEND   = 3'd2,
    WAIT_Z = 3'd3,
    RETURN = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: selects one of two requesters.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   stb0, stb1   request strobes of requester 0 / 1
//   last_grant   index of the requester served most recently
//   grant_valid  at least one requester is asking
//   grant_idx    chosen requester (meaningful only when grant_valid)
module rr_pick2 (
  input  logic stb0,
  input  logic stb1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  assign grant_valid = stb0 | stb1;

  // On a tie the requester not served last wins; otherwise whoever asks.
  assign grant_idx = (stb0 & stb1) ? ~last_grant : stb1;

endmodule

// File: rtl/double_adder_arbiter.sv
// Shares one external double_adder between two stb/ack requesters, one addition at a time.
// Latency: 4 cycles of overhead plus adder latency plus the requester's result-ack latency.
// Backpressure: a held-off result keeps the arbiter busy; other requests wait with stb high.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   reqN_a/b, reqN_stb, reqN_ack  requester N operand handshake (N = 0, 1)
//   resN_z, resN_stb, resN_ack    requester N result handshake
//   adder_a/_stb/_ack             operand A towards the adder
//   adder_b/_stb/_ack             operand B towards the adder
//   adder_z/_stb/_ack             sum returned by the adder
//   busy                          high whenever a transaction is in flight
module double_adder_arbiter
  import double_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_stb,
  output logic             req0_ack,
  output logic [WIDTH-1:0] res0_z,
  output logic             res0_stb,
  input  logic             res0_ack,
  // requester 1
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_stb,
  output logic             req1_ack,
  output logic [WIDTH-1:0] res1_z,
  output logic             res1_stb,
  input  logic             res1_ack,
  // shared adder
  output logic [WIDTH-1:0] adder_a,
  output logic             adder_a_stb,
  input  logic             adder_a_ack,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_b_stb,
  input  logic             adder_b_ack,
  input  logic [WIDTH-1:0] adder_z,
  input  logic             adder_z_stb,
  output logic             adder_z_ack,
  // status
  output logic             busy
);

  arb_state_t       r_state;
  logic             r_grant;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_req0_ack;
  logic             r_req1_ack;
  logic             r_adder_a_stb;
  logic             r_adder_b_stb;
  logic             r_adder_z_ack;
  logic [WIDTH-1:0] r_res0_z;
  logic [WIDTH-1:0] r_res1_z;
  logic             r_res0_stb;
  logic             r_res1_stb;

  logic w_grant_valid;
  logic w_grant_idx;
  logic w_a_pending;
  logic w_b_pending;
  logic w_res_fire;

  rr_pick2 u_pick (
    .stb0        (req0_stb),
    .stb1        (req1_stb),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // An operand is still outstanding if its stb is high and not being taken
  // this edge; SEND exits once neither is outstanding, so both operands
  // clearing on the same edge is handled naturally.
  assign w_a_pending = r_adder_a_stb & ~adder_a_ack;
  assign w_b_pending = r_adder_b_stb & ~adder_b_ack;

  // Result handshake of whichever requester owns the current transaction.
  assign w_res_fire = r_grant ? (r_res1_stb & res1_ack) : (r_res0_stb & res0_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_grant       <= 1'b0;
      r_last_grant  <= 1'b1;  // requester 0 wins the first tie
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_req0_ack    <= 1'b0;
      r_req1_ack    <= 1'b0;
      r_adder_a_stb <= 1'b0;
      r_adder_b_stb <= 1'b0;
      r_adder_z_ack <= 1'b0;
      r_res0_z      <= '0;
      r_res1_z      <= '0;
      r_res0_stb    <= 1'b0;
      r_res1_stb    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_grant    <= w_grant_idx;
            r_op_a     <= w_grant_idx ? req1_a : req0_a;
            r_op_b     <= w_grant_idx ? req1_b : req0_b;
            r_req0_ack <= ~w_grant_idx;
            r_req1_ack <= w_grant_idx;
            r_state    <= ACCEPT;
          end
        end
        ACCEPT: begin
          // The requester's stb is still high, so its transfer completes now.
          r_req0_ack    <= 1'b0;
          r_req1_ack    <= 1'b0;
          r_adder_a_stb <= 1'b1;
          r_adder_b_stb <= 1'b1;
          r_state       <= SEND;
        end
        SEND: begin
          if (adder_a_ack) r_adder_a_stb <= 1'b0;
          if (adder_b_ack) r_adder_b_stb <= 1'b0;
          if (!w_a_pending && !w_b_pending) begin
            r_adder_z_ack <= 1'b1;
            r_state       <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (adder_z_stb && r_adder_z_ack) begin
            if (r_grant) begin
              r_res1_z   <= adder_z;
              r_res1_stb <= 1'b1;
            end else begin
              r_res0_z   <= adder_z;
              r_res0_stb <= 1'b1;
            end
            r_adder_z_ack <= 1'b0;
            r_state       <= RETURN;
          end
        end
        RETURN: begin
          if (w_res_fire) begin
            r_res0_stb   <= 1'b0;
            r_res1_stb   <= 1'b0;
            r_last_grant <= r_grant;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_ack    = r_req0_ack;
  assign req1_ack    = r_req1_ack;
  assign res0_z      = r_res0_z;
  assign res1_z      = r_res1_z;
  assign res0_stb    = r_res0_stb;
  assign res1_stb    = r_res1_stb;
  assign adder_a     = r_op_a;
  assign adder_b     = r_op_b;
  assign adder_a_stb = r_adder_a_stb;
  assign adder_b_stb = r_adder_b_stb;
  assign adder_z_ack = r_adder_z_ack;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_double_adder_arbiter.sv
// Self-checking bench for double_adder_arbiter with a behavioural double_adder stand-in.
// Latency: n/a (bench).
// Backpressure: adder ack delays and requester result-ack delays are programmable.
module tb_double_adder_arbiter;

  localparam logic [63:0] D_ONE     = 64'h3FF0000000000000;
  localparam logic [63:0] D_TWO     = 64'h4000000000000000;
  localparam logic [63:0] D_THREE   = 64'h4008000000000000;
  localparam logic [63:0] D_HALF    = 64'h3FE0000000000000;
  localparam logic [63:0] D_QUARTER = 64'h3FD0000000000000;
  localparam logic [63:0] D_P75     = 64'h3FE8000000000000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_stb, req1_stb, res0_ack, res1_ack;
  logic        adder_a_ack, adder_b_ack, adder_z_stb;
  logic [63:0] adder_z;
  wire         req0_ack, req1_ack, res0_stb, res1_stb;
  wire  [63:0] res0_z, res1_z, adder_a, adder_b;
  wire         adder_a_stb, adder_b_stb, adder_z_ack, busy;

  double_adder_arbiter #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req0_a(req0_a), .req0_b(req0_b), .req0_stb(req0_stb), .req0_ack(req0_ack),
    .res0_z(res0_z), .res0_stb(res0_stb), .res0_ack(res0_ack),
    .req1_a(req1_a), .req1_b(req1_b), .req1_stb(req1_stb), .req1_ack(req1_ack),
    .res1_z(res1_z), .res1_stb(res1_stb), .res1_ack(res1_ack),
    .adder_a(adder_a), .adder_a_stb(adder_a_stb), .adder_a_ack(adder_a_ack),
    .adder_b(adder_b), .adder_b_stb(adder_b_stb), .adder_b_ack(adder_b_ack),
    .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // Reference model: each requester's results return in order, each equal
  // to the IEEE sum of its operands.
  function automatic logic [63:0] ref_sum(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rnd_d();
    real r;
    r = real'(int'($urandom_range(0, 4000))) / 16.0 - 125.0;
    return $realtobits(r);
  endfunction

  // Pending requests ({a,b}) and expected results per requester.
  logic [127:0] rq0[$], rq1[$];
  logic [63:0]  ex0[$], ex1[$];
  int           glog[$];  // requester index of each completed operand handshake

  // Programmable delays.
  int res_dly0, res_dly1, a_dly, b_dly, z_lat;
  logic bp_mon;

  // Engine state / monitors.
  int   cyc, res_wait0, res_wait1;
  logic s_req0, s_req1, s_res0, s_res1, s_a, s_b, s_z;
  int   ack0_hi, ack0_rise, stb0_rise, as_rise, as_fall, bs_fall, zack_rise, res1_hi;
  int   bp_cyc, bp_viol;
  logic [63:0] bp_z;
  logic p_ack0, p_as, p_bs, p_zack, p_r1s, e_ost;
  logic a_got, b_got, z_busy;
  int   a_cnt, b_cnt, z_cnt;
  logic [63:0] z_val;

  task automatic enq(input int n, input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    if (n == 0) begin rq0.push_back({a, b}); ex0.push_back(e); end
    else        begin rq1.push_back({a, b}); ex1.push_back(e); end
  endtask

  function automatic bit done();
    return rq0.size() == 0 && rq1.size() == 0 && ex0.size() == 0 && ex1.size() == 0 && !busy;
  endfunction

  task automatic wait_done(input int budget, input string tag);
    int i;
    i = 0;
    while (!done() && i < budget) begin
      @(negedge clk); #2;
      i++;
    end
    chk(tag, 64'(done()), 64'd1);
  endtask

  // Cycle engine: runs on every falling edge. Handshake flags are snapshots of
  // stb&ack taken at the previous falling edge, i.e. the values the rising
  // edge in between acted upon.
  initial begin : engine
    req0_stb = 0; req1_stb = 0; res0_ack = 0; res1_ack = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    adder_a_ack = 0; adder_b_ack = 0; adder_z_stb = 0; adder_z = '0;
    cyc = 0; res_wait0 = 0; res_wait1 = 0;
    {s_req0, s_req1, s_res0, s_res1, s_a, s_b, s_z} = '0;
    ack0_hi = 0; ack0_rise = 0; stb0_rise = 0; as_rise = 0; as_fall = 0; bs_fall = 0;
    zack_rise = 0; res1_hi = 0; bp_cyc = 0; bp_viol = 0; bp_z = '0;
    {p_ack0, p_as, p_bs, p_zack, p_r1s} = '0;
    a_got = 0; b_got = 0; z_busy = 0; a_cnt = 0; b_cnt = 0; z_cnt = 0; z_val = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        rq0.delete(); rq1.delete(); ex0.delete(); ex1.delete();
        req0_stb = 0; req1_stb = 0; res0_ack = 0; res1_ack = 0;
        adder_a_ack = 0; adder_b_ack = 0; adder_z_stb = 0; adder_z = '0;
        a_got = 0; b_got = 0; z_busy = 0; a_cnt = 0; b_cnt = 0; z_cnt = 0;
        res_wait0 = 0; res_wait1 = 0;
        {s_req0, s_req1, s_res0, s_res1, s_a, s_b, s_z} = '0;
        {p_ack0, p_as, p_bs, p_zack, p_r1s} = '0;
      end else begin
        // monitors on the currently visible outputs
        if (req0_ack) ack0_hi++;
        if (req0_ack && !p_ack0) ack0_rise = cyc;
        if (adder_a_stb && !p_as) as_rise = cyc;
        if (!adder_a_stb && p_as) as_fall = cyc;
        if (!adder_b_stb && p_bs) bs_fall = cyc;
        if (adder_z_ack && !p_zack) zack_rise = cyc;
        if (res1_stb) res1_hi++;
        if (res1_stb && !p_r1s) bp_z = res1_z;
        if (bp_mon && res1_stb && !res1_ack) begin
          bp_cyc++;
          if (res1_z !== bp_z || !busy || req0_ack || adder_a_stb || adder_b_stb) bp_viol++;
        end
        p_ack0 = req0_ack; p_as = adder_a_stb; p_bs = adder_b_stb;
        p_zack = adder_z_ack; p_r1s = res1_stb;

        // requester 0
        if (s_req0) begin void'(rq0.pop_front()); glog.push_back(0); end
        if (s_res0) begin
          chk("res0_pending", 64'(ex0.size() != 0), 64'd1);
          if (ex0.size() != 0) chk("res0_z", res0_z, ex0.pop_front());
          res_wait0 = 0;
        end
        res0_ack = 1'b0;
        if (res0_stb) begin res0_ack = (res_wait0 >= res_dly0); res_wait0++; end
        e_ost = req0_stb;
        req0_stb = (rq0.size() != 0);
        if (req0_stb) {req0_a, req0_b} = rq0[0];
        if (req0_stb && !e_ost) stb0_rise = cyc;

        // requester 1
        if (s_req1) begin void'(rq1.pop_front()); glog.push_back(1); end
        if (s_res1) begin
          chk("res1_pending", 64'(ex1.size() != 0), 64'd1);
          if (ex1.size() != 0) chk("res1_z", res1_z, ex1.pop_front());
          res_wait1 = 0;
        end
        res1_ack = 1'b0;
        if (res1_stb) begin res1_ack = (res_wait1 >= res_dly1); res_wait1++; end
        req1_stb = (rq1.size() != 0);
        if (req1_stb) {req1_a, req1_b} = rq1[0];

        // behavioural double_adder
        if (s_z) begin
          z_busy = 0; a_got = 0; b_got = 0; a_cnt = 0; b_cnt = 0; adder_z_stb = 0;
        end
        if (s_a) a_got = 1;
        if (s_b) b_got = 1;
        adder_a_ack = adder_a_stb && !a_got && (a_cnt >= a_dly);
        if (adder_a_stb && !a_got) a_cnt++;
        adder_b_ack = adder_b_stb && !b_got && (b_cnt >= b_dly);
        if (adder_b_stb && !b_got) b_cnt++;
        if (a_got && b_got && !z_busy) begin
          z_busy = 1; z_cnt = 0; z_val = ref_sum(adder_a, adder_b);
        end
        if (z_busy && !adder_z_stb) begin
          if (z_cnt >= z_lat) begin adder_z_stb = 1; adder_z = z_val; end
          else z_cnt++;
        end

        s_req0 = req0_stb & req0_ack;
        s_req1 = req1_stb & req1_ack;
        s_res0 = res0_stb & res0_ack;
        s_res1 = res1_stb & res1_ack;
        s_a    = adder_a_stb & adder_a_ack;
        s_b    = adder_b_stb & adder_b_ack;
        s_z    = adder_z_stb & adder_z_ack;
      end
    end
  end

  initial begin : main
    int base, b_ack, b_r1, bp0, v0, first, mism;
    logic [63:0] a, b;
    res_dly0 = 0; res_dly1 = 0; a_dly = 0; b_dly = 0; z_lat = 2; bp_mon = 0;

    // reset state
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ctl", 64'({req0_ack, req1_ack, res0_stb, res1_stb, adder_a_stb, adder_b_stb, adder_z_ack}), 64'd0);
    chk("rst_res0_z", res0_z, 64'd0);
    chk("rst_res1_z", res1_z, 64'd0);
    chk("rst_adder_a", adder_a, 64'd0);
    chk("rst_adder_b", adder_b, 64'd0);
    @(negedge clk); #2 rst = 1'b1;

    // simultaneous first requests: requester 0 wins the first tie
    base = glog.size();
    enq(0, D_ONE, D_TWO, D_THREE);
    enq(1, D_HALF, D_QUARTER, D_P75);
    wait_done(100, "t1_done");
    chk("t1_ngrant", 64'(glog.size() - base), 64'd2);
    if (glog.size() >= base + 2) begin
      chk("t1_first", 64'(glog[base]), 64'd0);
      chk("t1_second", 64'(glog[base + 1]), 64'd1);
    end

    // single request with ack/stb timing
    b_ack = ack0_hi; b_r1 = res1_hi;
    enq(0, D_ONE, D_TWO, D_THREE);
    wait_done(100, "t2_done");
    chk("t2_ack_cycles", 64'(ack0_hi - b_ack), 64'd1);
    chk("t2_ack_lat", 64'(ack0_rise - stb0_rise), 64'd1);
    chk("t2_adder_stb_lat", 64'(as_rise - ack0_rise), 64'd1);
    chk("t2_res1_stb", 64'(res1_hi - b_r1), 64'd0);

    // fairness: two continuous streams of 8 alternate strictly, the first
    // grant going to the requester not served last
    base = glog.size();
    first = 1 - glog[base - 1];
    for (int i = 0; i < 8; i++) begin
      a = rnd_d(); b = rnd_d(); enq(0, a, b, ref_sum(a, b));
      a = rnd_d(); b = rnd_d(); enq(1, a, b, ref_sum(a, b));
    end
    wait_done(1000, "t3_done");
    chk("t3_ngrant", 64'(glog.size() - base), 64'd16);
    mism = 0;
    for (int i = 0; i < 16 && base + i < glog.size(); i++)
      if (glog[base + i] != ((first + i) % 2)) mism++;
    chk("t3_alternate", 64'(mism), 64'd0);

    // result backpressure on requester 1 while requester 0 waits
    res_dly1 = 20;
    base = glog.size(); bp0 = bp_cyc; v0 = bp_viol;
    a = rnd_d(); b = rnd_d(); enq(1, a, b, ref_sum(a, b));
    for (int i = 0; i < 100 && !res1_stb; i++) begin @(negedge clk); #2; end
    chk("t4_res1_stb", 64'(res1_stb), 64'd1);
    bp_mon = 1;
    a = rnd_d(); b = rnd_d(); enq(0, a, b, ref_sum(a, b));
    wait_done(300, "t4_done");
    bp_mon = 0; res_dly1 = 0;
    chk("t4_hold_cycles", 64'((bp_cyc - bp0) >= 20), 64'd1);
    chk("t4_violations", 64'(bp_viol - v0), 64'd0);
    chk("t4_ngrant", 64'(glog.size() - base), 64'd2);
    if (glog.size() >= base + 2) begin
      chk("t4_first", 64'(glog[base]), 64'd1);
      chk("t4_second", 64'(glog[base + 1]), 64'd0);
    end

    // adder-side skew: operand B acked 5 cycles after operand A
    b_dly = 5;
    a = rnd_d(); b = rnd_d(); enq(0, a, b, ref_sum(a, b));
    wait_done(200, "t5_done");
    b_dly = 0;
    chk("t5_a_first", 64'(as_fall < bs_fall), 64'd1);
    chk("t5_skew", 64'(bs_fall - as_fall), 64'd5);
    chk("t5_zack_after_b", 64'(zack_rise), 64'(bs_fall));

    // reset during WAIT_Z
    z_lat = 10;
    a = rnd_d(); b = rnd_d(); enq(0, a, b, ref_sum(a, b));
    for (int i = 0; i < 100 && !adder_z_ack; i++) begin @(negedge clk); #2; end
    chk("t6_in_wait_z", 64'(adder_z_ack), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_ctl", 64'({req0_ack, req1_ack, res0_stb, res1_stb, adder_a_stb, adder_b_stb, adder_z_ack}), 64'd0);
    chk("t6_res0_z", res0_z, 64'd0);
    chk("t6_res1_z", res1_z, 64'd0);
    chk("t6_adder_a", adder_a, 64'd0);
    chk("t6_adder_b", adder_b, 64'd0);
    @(negedge clk); @(negedge clk); #2;
    rst = 1'b1; z_lat = 2;
    @(negedge clk); #2;
    base = glog.size();
    a = rnd_d(); b = rnd_d(); enq(1, a, b, ref_sum(a, b));
    wait_done(100, "t6_done");
    chk("t6_ngrant", 64'(glog.size() - base), 64'd1);
    if (glog.size() >= base + 1) chk("t6_grant", 64'(glog[base]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
